shift_sequencer: RTL and testbench

//  Sequences and shares the combinational barrel shifter between two requesters: port 0 (data-processing

---
 rtl/shift_sequencer_pkg.sv | 32 +++
 rtl/shift_sequencer_if.sv | 47 ++++
 rtl/shift_sequencer_resolver.sv | 70 +++++++
 rtl/shift_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_shift_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : shift_sequencer_pkg                                              |
// | Purpose : Shared word width, shift-type codes and sequencer state codes.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package shift_sequencer_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0,
    SH_LSR = 2'd1,
    SH_ASR = 2'd2,
    SH_ROR = 2'd3
  } sh_type_e;

  typedef enum logic [1:0] {
    SSEQ_IDLE = 2'd0,
    SSEQ_EXEC = 2'd1,
    SSEQ_RESP = 2'd2
  } sseq_state_e;

  localparam logic SSEQ_PORT_DP = 1'b0;
  localparam logic SSEQ_PORT_LS = 1'b1;

  function automatic logic [WORD_W-1:0] sign_fill(input logic msb);
    return {WORD_W{msb}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : shift_sequencer_if                                               |
// | Purpose : Request, shifter and response signals of the shift sequencer.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface shift_sequencer_if #(
  parameter int AMT_W = 8
);
  import shift_sequencer_pkg::*;

  logic [1:0]          in_Req_Valid;
  logic [1:0]          out_Req_Ready;
  logic [2*WORD_W-1:0] in_Req_Val;
  logic [2*AMT_W-1:0]  in_Req_Amt;
  logic [1:0]          in_Req_ByReg;
  logic [3:0]          in_Req_Type;
  logic                in_C_flag;
  logic [WORD_W-1:0]   out_Sh_Val;
  logic [4:0]          out_Sh_Amt;
  logic [1:0]          out_Sh_Type;
  logic                out_Sh_C;
  logic [WORD_W-1:0]   in_Sh_Op2;
  logic                in_Sh_Carry;
  logic                in_Flush;
  logic                out_Valid;
  logic                out_Port;
  logic [WORD_W-1:0]   out_Op2;
  logic                out_Carry;
  logic                in_Resp_Ready;

  modport slave (
    input  in_Req_Valid, in_Req_Val, in_Req_Amt, in_Req_ByReg, in_Req_Type, in_C_flag,
    input  in_Sh_Op2, in_Sh_Carry, in_Flush, in_Resp_Ready,
    output out_Req_Ready, out_Sh_Val, out_Sh_Amt, out_Sh_Type, out_Sh_C,
    output out_Valid, out_Port, out_Op2, out_Carry
  );

  modport master (
    output in_Req_Valid, in_Req_Val, in_Req_Amt, in_Req_ByReg, in_Req_Type, in_C_flag,
    output in_Sh_Op2, in_Sh_Carry, in_Flush, in_Resp_Ready,
    input  out_Req_Ready, out_Sh_Val, out_Sh_Amt, out_Sh_Type, out_Sh_C,
    input  out_Valid, out_Port, out_Op2, out_Carry
  );

endinterface
`default_nettype wire

// File: rtl/shift_sequencer_resolver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : shift_amount_resolver                                            |
// | Purpose : Maps register shift amounts (0..255) onto the 5-bit shifter or   |
// |           an overriding result the shifter cannot produce.                  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module shift_amount_resolver
  import shift_sequencer_pkg::*;
#(
  parameter int AMT_W = 8
) (
  input  logic [WORD_W-1:0] val_i,
  input  logic [AMT_W-1:0]  amt_i,
  input  logic              by_reg_i,
  input  sh_type_e          type_i,
  input  logic              c_i,
  output logic [4:0]        sh_amt_o,
  output logic              override_o,
  output logic [WORD_W-1:0] ovr_op2_o,
  output logic              ovr_carry_o
);

  logic amt_hi;
  logic amt_is_32;

  assign amt_hi    = |amt_i[AMT_W-1:5];
  assign amt_is_32 = (amt_i == AMT_W'(32));

  always_comb begin
    sh_amt_o    = amt_i[4:0];
    override_o  = 1'b0;
    ovr_op2_o   = val_i;
    ovr_carry_o = c_i;
    // Immediate amounts always go straight to the shifter with their own #0 meaning.
    if (by_reg_i) begin
      if (amt_i == '0) begin
        override_o = 1'b1;
      end else if (amt_hi) begin
        case (type_i)
          SH_LSL: begin
            override_o  = 1'b1;
            ovr_op2_o   = '0;
            ovr_carry_o = amt_is_32 & val_i[0];
          end
          SH_LSR: begin
            override_o  = 1'b1;
            ovr_op2_o   = '0;
            ovr_carry_o = amt_is_32 & val_i[WORD_W-1];
          end
          SH_ASR: begin
            override_o  = 1'b1;
            ovr_op2_o   = sign_fill(val_i[WORD_W-1]);
            ovr_carry_o = val_i[WORD_W-1];
          end
          default: begin
            // Rotations by a multiple of 32 leave the value intact; otherwise rotate by amt mod 32.
            if (amt_i[4:0] == 5'd0) begin
              override_o  = 1'b1;
              ovr_op2_o   = val_i;
              ovr_carry_o = val_i[WORD_W-1];
            end
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : shift_sequencer                                                  |
// | Purpose : Arbitrates two requesters onto one barrel shifter and returns    |
// |           the registered result. SHIFT_SEQ_RR_EN selects round-robin grant. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int AMT_W = 8
) (
  input  logic             in_Clk,
  input  logic             in_Rst,
  shift_sequencer_if.slave bus
);

  localparam int W = WORD_W;

  sseq_state_e      state_q, state_d;
  logic [W-1:0]     val_q, val_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic             by_reg_q, by_reg_d;
  sh_type_e         type_q, type_d;
  logic             c_q, c_d;
  logic             port_q, port_d;
  logic [W-1:0]     op2_q, op2_d;
  logic             carry_q, carry_d;

  logic [1:0]       req_grant;
  logic [1:0]       grant_eff;
  logic             acc_port;

  logic [4:0]       res_sh_amt;
  logic             res_override;
  logic [W-1:0]     res_op2;
  logic             res_carry;

  logic [W-1:0]     sh_val;
  logic [4:0]       sh_amt;
  logic [1:0]       sh_type;
  logic             sh_c;

`ifdef SHIFT_SEQ_RR_EN
  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    if (&bus.in_Req_Valid) begin
      req_grant = rr_ptr_q ? 2'b10 : 2'b01;
    end else begin
      req_grant = bus.in_Req_Valid;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|grant_eff) begin
      rr_ptr_d = ~acc_port;
    end
  end

  always_ff @(posedge in_Clk) begin
    if (in_Rst) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  always_comb begin
    req_grant = bus.in_Req_Valid[0] ? 2'b01 : {bus.in_Req_Valid[1], 1'b0};
  end
`endif

  // Accept only from IDLE; a flush or reset in that cycle blocks the handshake.
  always_comb begin
    grant_eff = 2'b00;
    if ((state_q == SSEQ_IDLE) && !bus.in_Flush && !in_Rst) begin
      grant_eff = req_grant;
    end
  end

  assign acc_port          = grant_eff[1];
  assign bus.out_Req_Ready = grant_eff;

  shift_amount_resolver #(
    .AMT_W (AMT_W)
  ) u_resolver (
    .val_i       (val_q),
    .amt_i       (amt_q),
    .by_reg_i    (by_reg_q),
    .type_i      (type_q),
    .c_i         (c_q),
    .sh_amt_o    (res_sh_amt),
    .override_o  (res_override),
    .ovr_op2_o   (res_op2),
    .ovr_carry_o (res_carry)
  );

  always_comb begin
    state_d  = state_q;
    val_d    = val_q;
    amt_d    = amt_q;
    by_reg_d = by_reg_q;
    type_d   = type_q;
    c_d      = c_q;
    port_d   = port_q;
    op2_d    = op2_q;
    carry_d  = carry_q;
    case (state_q)
      SSEQ_IDLE: begin
        if (|grant_eff) begin
          port_d   = acc_port ? SSEQ_PORT_LS : SSEQ_PORT_DP;
          val_d    = acc_port ? bus.in_Req_Val[2*W-1:W] : bus.in_Req_Val[W-1:0];
          amt_d    = acc_port ? bus.in_Req_Amt[2*AMT_W-1:AMT_W] : bus.in_Req_Amt[AMT_W-1:0];
          by_reg_d = bus.in_Req_ByReg[acc_port];
          type_d   = sh_type_e'(acc_port ? bus.in_Req_Type[3:2] : bus.in_Req_Type[1:0]);
          c_d      = bus.in_C_flag;
          state_d  = SSEQ_EXEC;
        end
      end
      SSEQ_EXEC: begin
        if (bus.in_Flush) begin
          state_d = SSEQ_IDLE;
        end else begin
          op2_d   = res_override ? res_op2 : bus.in_Sh_Op2;
          carry_d = res_override ? res_carry : bus.in_Sh_Carry;
          state_d = SSEQ_RESP;
        end
      end
      SSEQ_RESP: begin
        if (bus.in_Flush || bus.in_Resp_Ready) begin
          state_d = SSEQ_IDLE;
        end
      end
      default: begin
        state_d = SSEQ_IDLE;
      end
    endcase
  end

  // The shifter only sees the captured operation while in EXEC; otherwise it is held at zero.
  always_comb begin
    sh_val  = '0;
    sh_amt  = '0;
    sh_type = '0;
    sh_c    = 1'b0;
    if (state_q == SSEQ_EXEC) begin
      sh_val  = val_q;
      sh_amt  = res_sh_amt;
      sh_type = type_q;
      sh_c    = c_q;
    end
  end

  assign bus.out_Sh_Val  = sh_val;
  assign bus.out_Sh_Amt  = sh_amt;
  assign bus.out_Sh_Type = sh_type;
  assign bus.out_Sh_C    = sh_c;

  assign bus.out_Valid = (state_q == SSEQ_RESP);
  assign bus.out_Port  = port_q;
  assign bus.out_Op2   = op2_q;
  assign bus.out_Carry = carry_q;

  always_ff @(posedge in_Clk) begin
    if (in_Rst) begin
      state_q  <= SSEQ_IDLE;
      val_q    <= '0;
      amt_q    <= '0;
      by_reg_q <= 1'b0;
      type_q   <= SH_LSL;
      c_q      <= 1'b0;
      port_q   <= 1'b0;
      op2_q    <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      val_q    <= val_d;
      amt_q    <= amt_d;
      by_reg_q <= by_reg_d;
      type_q   <= type_d;
      c_q      <= c_d;
      port_q   <= port_d;
      op2_q    <= op2_d;
      carry_q  <= carry_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_shift_sequencer                                               |
// | Purpose : Randomized and directed checks of shift_sequencer against an    |
// |           arithmetic reference model, with a behavioural barrel shifter.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;
`ifdef SHIFT_SEQ_RR_EN
  int   rr_ptr  = 0;
`endif

  logic [1:0]  rv_m;
  logic [31:0] rv_v0, rv_v1;
  logic [7:0]  rv_a0, rv_a1;
  logic [1:0]  rv_br;
  logic [3:0]  rv_t;
  logic        rv_c;

  shift_sequencer_if #(.AMT_W(8)) bus ();

  shift_sequencer #(.AMT_W(8)) dut (
    .in_Clk (clk),
    .in_Rst (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Barrel shifter with ARM immediate #0 semantics (LSL#0, LSR#32, ASR#32, RRX).
  logic [31:0] sh_res;
  logic        sh_cout;
  int          sh_n;
  always_comb begin
    sh_n    = int'(bus.out_Sh_Amt);
    sh_res  = bus.out_Sh_Val;
    sh_cout = bus.out_Sh_C;
    case (bus.out_Sh_Type)
      2'd0: begin
        if (sh_n != 0) begin
          sh_res  = bus.out_Sh_Val << sh_n;
          sh_cout = bus.out_Sh_Val[32-sh_n];
        end
      end
      2'd1: begin
        if (sh_n == 0) begin
          sh_res  = '0;
          sh_cout = bus.out_Sh_Val[31];
        end else begin
          sh_res  = bus.out_Sh_Val >> sh_n;
          sh_cout = bus.out_Sh_Val[sh_n-1];
        end
      end
      2'd2: begin
        if (sh_n == 0) begin
          sh_res  = {32{bus.out_Sh_Val[31]}};
          sh_cout = bus.out_Sh_Val[31];
        end else begin
          sh_res  = $signed(bus.out_Sh_Val) >>> sh_n;
          sh_cout = bus.out_Sh_Val[sh_n-1];
        end
      end
      default: begin
        if (sh_n == 0) begin
          sh_res  = {bus.out_Sh_C, bus.out_Sh_Val[31:1]};
          sh_cout = bus.out_Sh_Val[0];
        end else begin
          sh_res  = (bus.out_Sh_Val >> sh_n) | (bus.out_Sh_Val << (32 - sh_n));
          sh_cout = bus.out_Sh_Val[sh_n-1];
        end
      end
    endcase
  end
  assign bus.in_Sh_Op2   = sh_res;
  assign bus.in_Sh_Carry = sh_cout;

  // Reference result {carry, op2}: wide-word shifts so over-range amounts fall out naturally.
  function automatic logic [32:0] ref_shift(input logic [31:0] v, input logic [7:0] a,
                                            input logic br, input logic [1:0] t, input logic c);
    int n;
    int rot;
    logic [63:0] w;
    logic signed [63:0] s;
    if (br) begin
      n = int'(a);
    end else begin
      n = int'(a[4:0]);
      if (n == 0 && (t == SH_LSR || t == SH_ASR)) n = 32;
      if (n == 0 && t == SH_ROR) return {v[0], c, v[31:1]};
    end
    if (n == 0) return {c, v};
    case (t)
      SH_LSL: begin
        w = {32'b0, v} << n;
        return {w[32], w[31:0]};
      end
      SH_LSR: begin
        w = {v, 32'b0} >> n;
        return {w[31], w[63:32]};
      end
      SH_ASR: begin
        s = $signed({v, 32'b0});
        s = s >>> n;
        return {s[31], s[63:32]};
      end
      default: begin
        rot = n % 32;
        if (rot == 0) return {v[31], v};
        w = {v, v} >> rot;
        return {w[31], w[31:0]};
      end
    endcase
  endfunction

  function automatic int expect_grant(input logic [1:0] m);
    if (m == 2'b11) begin
`ifdef SHIFT_SEQ_RR_EN
      return rr_ptr;
`else
      return 0;
`endif
    end
    return m[1] ? 1 : 0;
  endfunction

  function automatic logic [7:0] rand_amt();
    case ($urandom_range(0, 3))
      0:       return 8'd0;
      1:       return 8'($urandom_range(1, 31));
      2:       return 8'($urandom_range(32, 33));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic model_accept(input int e);
`ifdef SHIFT_SEQ_RR_EN
    rr_ptr = 1 - e;
`else
    if (e != 0 && e != 1) $display("note: odd port %0d", e);
`endif
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_result(input string tag, input int e, input logic [32:0] exp);
    check_eq({tag, "_valid"}, 64'(bus.out_Valid), 64'(1));
    check_eq({tag, "_port"},  64'(bus.out_Port),  64'(e));
    check_eq({tag, "_op2"},   64'(bus.out_Op2),   64'(exp[31:0]));
    check_eq({tag, "_carry"}, 64'(bus.out_Carry), 64'(exp[32]));
  endtask

  // One full operation starting in IDLE at a negedge; ends back in IDLE.
  task automatic transact(input logic [1:0] vmask, input logic [31:0] v0, input logic [31:0] v1,
                          input logic [7:0] a0, input logic [7:0] a1, input logic [1:0] br,
                          input logic [1:0] t0, input logic [1:0] t1, input logic c, input int hold);
    int e;
    logic [32:0] exp;
    e   = expect_grant(vmask);
    exp = (e == 1) ? ref_shift(v1, a1, br[1], t1, c) : ref_shift(v0, a0, br[0], t0, c);
    bus.in_Req_Valid = vmask;
    bus.in_Req_Val   = {v1, v0};
    bus.in_Req_Amt   = {a1, a0};
    bus.in_Req_ByReg = br;
    bus.in_Req_Type  = {t1, t0};
    bus.in_C_flag    = c;
    #1 check_eq("ready", 64'(bus.out_Req_Ready), 64'(2'b01 << e));
    model_accept(e);
    @(negedge clk);
    bus.in_Req_Valid = 2'b00;
    bus.in_Req_Val   = '1;
    bus.in_C_flag    = ~c;
    #1 check_eq("exec_valid", 64'(bus.out_Valid), 64'(0));
    @(negedge clk);
    #1 check_result("resp", e, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1 check_result("hold", e, exp);
    end
    bus.in_Resp_Ready = 1'b1;
    @(negedge clk);
    bus.in_Resp_Ready = 1'b0;
    #1 check_eq("done_valid", 64'(bus.out_Valid), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst               = 1'b1;
    bus.in_Req_Valid  = 2'b11;
    bus.in_Req_Val    = '0;
    bus.in_Req_Amt    = '0;
    bus.in_Req_ByReg  = '0;
    bus.in_Req_Type   = '0;
    bus.in_C_flag     = 1'b0;
    bus.in_Flush      = 1'b0;
    bus.in_Resp_Ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_ready", 64'(bus.out_Req_Ready), 64'(0));
    check_eq("rst_valid", 64'(bus.out_Valid), 64'(0));
    check_eq("rst_port",  64'(bus.out_Port), 64'(0));
    check_eq("rst_op2",   64'(bus.out_Op2), 64'(0));
    check_eq("rst_carry", 64'(bus.out_Carry), 64'(0));
    check_eq("rst_sh",    64'({bus.out_Sh_Val, bus.out_Sh_Amt, bus.out_Sh_Type, bus.out_Sh_C}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    bus.in_Req_Valid = 2'b00;

    // Directed register/immediate amount cases.
    transact(2'b01, 32'h0000_00F1, 32'h0, 8'd4,   8'd0,  2'b01, SH_LSL, SH_LSL, 1'b0, 0);
    transact(2'b10, 32'h0, 32'h8000_0001, 8'd0,   8'd32, 2'b10, SH_LSL, SH_LSR, 1'b0, 0);
    transact(2'b10, 32'h0, 32'h8000_0001, 8'd0,   8'd33, 2'b10, SH_LSL, SH_LSR, 1'b0, 0);
    transact(2'b01, 32'h8000_0000, 32'h0, 8'd200, 8'd0,  2'b01, SH_ASR, SH_LSL, 1'b0, 0);
    transact(2'b01, 32'h8000_0001, 32'h0, 8'd64,  8'd0,  2'b01, SH_ROR, SH_LSL, 1'b0, 0);
    transact(2'b01, 32'h0000_0003, 32'h0, 8'd0,   8'd0,  2'b01, SH_ROR, SH_LSL, 1'b1, 0);
    transact(2'b01, 32'h0000_0003, 32'h0, 8'd0,   8'd0,  2'b00, SH_ROR, SH_LSL, 1'b1, 0);
    transact(2'b10, 32'h0, 32'h0000_0001, 8'd0,   8'd32, 2'b10, SH_LSL, SH_LSL, 1'b0, 1);

    // Both ports requesting: grant order depends on the arbitration mode.
    for (int i = 0; i < 4; i++) begin
      transact(2'b11, 32'h1111_0000 + i, 32'h2222_0000 + i, 8'd1, 8'd2, 2'b11,
               SH_LSL, SH_LSR, 1'b0, (i == 0) ? 3 : 0);
    end

    // Flush while in EXEC drops the result and returns to IDLE.
    bus.in_Req_Valid = 2'b01;
    bus.in_Req_Val   = {32'h0, 32'h0000_1234};
    bus.in_Req_Amt   = {8'd0, 8'd3};
    bus.in_Req_ByReg = 2'b01;
    bus.in_Req_Type  = 4'd0;
    bus.in_C_flag    = 1'b0;
    #1 check_eq("fl_ready", 64'(bus.out_Req_Ready), 64'(2'b01));
    model_accept(0);
    @(negedge clk);
    bus.in_Req_Valid = 2'b00;
    bus.in_Flush     = 1'b1;
    @(negedge clk);
    bus.in_Flush = 1'b0;
    #1 check_eq("flush_exec_valid", 64'(bus.out_Valid), 64'(0));
    transact(2'b10, 32'h0, 32'hF000_000F, 8'd0, 8'd4, 2'b10, SH_LSL, SH_ROR, 1'b0, 0);

    // Flush in IDLE blocks the accept.
    bus.in_Req_Valid = 2'b01;
    bus.in_Flush     = 1'b1;
    #1 check_eq("flush_idle_ready", 64'(bus.out_Req_Ready), 64'(0));
    @(negedge clk);
    bus.in_Req_Valid = 2'b00;
    bus.in_Flush     = 1'b0;
    @(negedge clk);
    #1 check_eq("flush_idle_noacc", 64'(bus.out_Valid), 64'(0));

    // Flush together with Resp_Ready in RESP.
    bus.in_Req_Valid = 2'b01;
    bus.in_Req_Val   = {32'h0, 32'h0000_00FF};
    bus.in_Req_Amt   = {8'd0, 8'd1};
    #1 check_eq("fr_ready", 64'(bus.out_Req_Ready), 64'(2'b01));
    model_accept(0);
    @(negedge clk);
    bus.in_Req_Valid = 2'b00;
    @(negedge clk);
    #1 check_eq("fr_pre_valid", 64'(bus.out_Valid), 64'(1));
    bus.in_Flush      = 1'b1;
    bus.in_Resp_Ready = 1'b1;
    @(negedge clk);
    bus.in_Flush      = 1'b0;
    bus.in_Resp_Ready = 1'b0;
    #1 check_eq("fr_valid", 64'(bus.out_Valid), 64'(0));

    // Reset while in RESP clears every output.
    bus.in_Req_Valid = 2'b01;
    bus.in_Req_Val   = {32'h0, 32'hFFFF_FFFF};
    bus.in_Req_Amt   = {8'd0, 8'd1};
    bus.in_Req_ByReg = 2'b01;
    bus.in_Req_Type  = 4'd0;
    #1 check_eq("rm_ready", 64'(bus.out_Req_Ready), 64'(2'b01));
    model_accept(0);
    @(negedge clk);
    bus.in_Req_Valid = 2'b00;
    @(negedge clk);
    #1 check_eq("rm_pre_op2", 64'(bus.out_Op2), 64'(32'hFFFF_FFFE));
    rst              = 1'b1;
    bus.in_Req_Valid = 2'b11;
    @(negedge clk);
    #1;
    check_eq("rm_ready", 64'(bus.out_Req_Ready), 64'(0));
    check_eq("rm_valid", 64'(bus.out_Valid), 64'(0));
    check_eq("rm_port",  64'(bus.out_Port), 64'(0));
    check_eq("rm_op2",   64'(bus.out_Op2), 64'(0));
    check_eq("rm_carry", 64'(bus.out_Carry), 64'(0));
    check_eq("rm_sh",    64'({bus.out_Sh_Val, bus.out_Sh_Amt, bus.out_Sh_Type, bus.out_Sh_C}), 64'(0));
    @(negedge clk);
    rst              = 1'b0;
    bus.in_Req_Valid = 2'b00;
`ifdef SHIFT_SEQ_RR_EN
    rr_ptr = 0;
`endif
    transact(2'b11, 32'h0000_0010, 32'h0000_0020, 8'd1, 8'd1, 2'b11, SH_LSL, SH_LSL, 1'b0, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 60; i++) begin
      rv_m  = 2'($urandom_range(1, 3));
      rv_v0 = $urandom;
      rv_v1 = $urandom;
      rv_a0 = rand_amt();
      rv_a1 = rand_amt();
      rv_br = 2'($urandom);
      rv_t  = 4'($urandom);
      rv_c  = 1'($urandom);
      transact(rv_m, rv_v0, rv_v1, rv_a0, rv_a1, rv_br, rv_t[1:0], rv_t[3:2], rv_c,
               int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
